// File: rtl/mem_arbiter.sv
// mem_arbiter: time-multiplexes one single-port memory between a cpu and a DMA engine.
// The cpu keeps the bus >= CPU_MIN cycles between DMA bursts; bursts last <= BURST_MAX cycles.
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int CPU_MIN   = 4,
    parameter int BURST_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_rdy,
    input  logic          i_dma_req,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_wdata,
    output logic          o_dma_gnt,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [DW-1:0] o_rd_data,
    output logic          o_owner
);
    localparam int CW = CPU_MIN > 1 ? $clog2(CPU_MIN) : 1;
    localparam int BW = BURST_MAX > 1 ? $clog2(BURST_MAX) : 1;
    localparam logic [CW-1:0] CPU_LAST = CW'(CPU_MIN - 1);
    localparam logic [BW-1:0] DMA_LAST = BW'(BURST_MAX - 1);

    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

    owner_e        r_owner, w_owner_nxt;
    logic [CW-1:0] r_cpu_cnt, w_cpu_cnt_nxt;
    logic [BW-1:0] r_dma_cnt, w_dma_cnt_nxt;
    logic          w_dma;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner   <= OWN_CPU;
            r_cpu_cnt <= '0;
            r_dma_cnt <= '0;
        end else begin
            r_owner   <= w_owner_nxt;
            r_cpu_cnt <= w_cpu_cnt_nxt;
            r_dma_cnt <= w_dma_cnt_nxt;
        end
    end

    // cpu_cnt saturates so an idle cpu lets DMA in on the very next cycle
    always_comb begin
        w_owner_nxt   = r_owner;
        w_cpu_cnt_nxt = r_cpu_cnt;
        w_dma_cnt_nxt = r_dma_cnt;
        if (r_owner == OWN_CPU) begin
            w_cpu_cnt_nxt = (r_cpu_cnt == CPU_LAST) ? r_cpu_cnt : r_cpu_cnt + 1'b1;
            if (i_dma_req && (r_cpu_cnt == CPU_LAST || !i_cpu_req)) begin
                w_owner_nxt   = OWN_DMA;
                w_dma_cnt_nxt = '0;
            end
        end else begin
            w_dma_cnt_nxt = (r_dma_cnt == DMA_LAST) ? '0 : r_dma_cnt + 1'b1;
            if (!i_dma_req || (r_dma_cnt == DMA_LAST && i_cpu_req)) begin
                w_owner_nxt   = OWN_CPU;
                w_cpu_cnt_nxt = '0;
            end
        end
    end

    // mem_we is gated by reset so nothing is written while the arbiter is held
    always_comb begin
        w_dma       = (r_owner == OWN_DMA);
        o_owner     = w_dma;
        o_cpu_rdy   = !w_dma;
        o_dma_gnt   = w_dma && i_dma_req;
        o_mem_addr  = w_dma ? i_dma_addr : i_cpu_addr;
        o_mem_wdata = w_dma ? i_dma_wdata : i_cpu_wdata;
        o_mem_we    = i_rst_n && (w_dma ? (i_dma_we && i_dma_req) : (i_cpu_we && i_cpu_req));
        o_rd_data   = i_mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a cycle-count reference model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] cpu_addr = '0, dma_addr = '0;
    logic [7:0]  cpu_wdata = '0, dma_wdata = '0;

    logic        cpu_rdy0, dma_gnt0, mem_we0, owner0;
    logic [15:0] mem_addr0;
    logic [7:0]  mem_wdata0, mem_rdata0, rd_data0;
    logic        cpu_rdy1, dma_gnt1, mem_we1, owner1;
    logic [15:0] mem_addr1;
    logic [7:0]  mem_wdata1, rd_data1;
    logic [7:0]  mem_rdata1 = 8'h3C;

    logic [7:0] mem [0:1023] = '{default: 8'h00};
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

    int total = 0, bad = 0, gcnt = 0;
    int m_own[2], m_cc[2], m_dc[2];

    always #5 clk = ~clk;

    mem_arbiter u0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdy(cpu_rdy0),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_gnt(dma_gnt0),
        .o_mem_addr(mem_addr0), .o_mem_we(mem_we0), .o_mem_wdata(mem_wdata0),
        .i_mem_rdata(mem_rdata0), .o_rd_data(rd_data0), .o_owner(owner0)
    );

    mem_arbiter #(.CPU_MIN(1), .BURST_MAX(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdy(cpu_rdy1),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_gnt(dma_gnt1),
        .o_mem_addr(mem_addr1), .o_mem_we(mem_we1), .o_mem_wdata(mem_wdata1),
        .i_mem_rdata(mem_rdata1), .o_rd_data(rd_data1), .o_owner(owner1)
    );

    assign mem_rdata0 = mem[mem_addr0[9:0]];
    always @(posedge clk) if (mem_we0) mem[mem_addr0[9:0]] <= mem_wdata0;

    function automatic int cmin(input int k);
        return k == 0 ? 4 : 1;
    endfunction

    function automatic int bmax(input int k);
        return k == 0 ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] e_addr(input int k);
        return m_own[k] != 0 ? dma_addr : cpu_addr;
    endfunction

    function automatic logic e_we(input int k);
        return rst_n && (m_own[k] != 0 ? (dma_we && dma_req) : (cpu_we && cpu_req));
    endfunction

    task automatic check_all();
        chk("owner0", owner0, m_own[0]);
        chk("cpu_rdy0", cpu_rdy0, m_own[0] == 0);
        chk("dma_gnt0", dma_gnt0, m_own[0] != 0 && dma_req);
        chk("mem_addr0", mem_addr0, e_addr(0));
        chk("mem_we0", mem_we0, e_we(0));
        chk("mem_wdata0", mem_wdata0, m_own[0] != 0 ? dma_wdata : cpu_wdata);
        chk("rd_data0", rd_data0, ref_mem[e_addr(0) % 1024]);
        chk("owner1", owner1, m_own[1]);
        chk("cpu_rdy1", cpu_rdy1, m_own[1] == 0);
        chk("dma_gnt1", dma_gnt1, m_own[1] != 0 && dma_req);
        chk("mem_addr1", mem_addr1, e_addr(1));
        chk("mem_we1", mem_we1, e_we(1));
        chk("rd_data1", rd_data1, 8'h3C);
    endtask

    // m_cc / m_dc count whole cycles owned since the last hand-over
    task automatic model_next();
        if (e_we(0)) ref_mem[e_addr(0) % 1024] = m_own[0] != 0 ? dma_wdata : cpu_wdata;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_own[k] = 0; m_cc[k] = 0; m_dc[k] = 0;
            end else if (m_own[k] == 0) begin
                if (dma_req && (m_cc[k] >= cmin(k) - 1 || !cpu_req)) begin
                    m_own[k] = 1; m_dc[k] = 0;
                end else m_cc[k]++;
            end else if (!dma_req || ((m_dc[k] % bmax(k)) == bmax(k) - 1 && cpu_req)) begin
                m_own[k] = 0; m_cc[k] = 0;
            end else m_dc[k]++;
        end
    endtask

    task automatic cyc(input logic r, input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [7:0] cd, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [7:0] dd);
        @(negedge clk);
        rst_n = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        if (!rst_n) for (int k = 0; k < 2; k++) begin m_own[k] = 0; m_cc[k] = 0; m_dc[k] = 0; end
        #1;
        check_all();
        gcnt += int'(dma_gnt0);
        model_next();
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_own[k] = 0; m_cc[k] = 0; m_dc[k] = 0; end
        do_reset();
        chk("reset_rdy", cpu_rdy0, 1'b1);
        chk("reset_owner", owner0, 1'b0);
        // reset dropped mid-burst while DMA is writing
        cyc(1, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0150, 8'h11);
        cyc(1, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0150, 8'h22);
        chk("burst_active", owner0, 1'b1);
        cyc(0, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0155, 8'hEE);
        chk("rst_owner", owner0, 1'b0);
        chk("rst_cpu_rdy", cpu_rdy0, 1'b1);
        chk("rst_mem_we", mem_we0, 1'b0);
        cyc(0, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0155, 8'hEE);
        chk("no_write_in_reset", mem[10'h155], 8'h00);
        chk("burst_write_done", mem[10'h150], 8'h22);
        // both requesting: 4 cpu / 4 dma, and 1/1 alternation on u1
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 8) gcnt = 0;
            cyc(1, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0020, 8'h00);
            chk("pattern_4_4", owner0, (i % 8) >= 4);
            chk("pattern_1_1", owner1, i % 2);
        end
        chk("gnts_per_8", gcnt, 4);
        // idle cpu: DMA owns the bus from cycle 1 and keeps it across wraps
        do_reset();
        gcnt = 0;
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0030, 8'h00);
        chk("dma_only_gnts", gcnt, 10);
        chk("dma_only_owner", owner0, 1'b1);
        // DMA writes A5 to 0x0200, cpu read of 0x0200 returns it after release
        do_reset();
        gcnt = 0;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 16'h0200, 8'h00, 0, 0, 16'h0200, 8'hA5);
        cyc(1, 1, 0, 16'h0200, 8'h00, 1, 1, 16'h0200, 8'hA5);
        cyc(1, 1, 0, 16'h0200, 8'h00, 1, 1, 16'h0200, 8'hA5);
        chk("write_stall", cpu_rdy0, 1'b0);
        chk("write_addr", mem_addr0, 16'h0200);
        cyc(1, 1, 0, 16'h0200, 8'h00, 0, 0, 16'h0200, 8'hA5);
        cyc(1, 1, 0, 16'h0200, 8'h00, 0, 0, 16'h0200, 8'hA5);
        chk("cpu_resumes", cpu_rdy0, 1'b1);
        chk("cpu_read_a5", rd_data0, 8'hA5);
        chk("single_gnt", gcnt, 1);
        // short DMA request timed to cpu_cnt==3
        do_reset();
        gcnt = 0;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 16'h0040, 8'h00, 0, 0, 16'h1234, 8'h00);
        cyc(1, 1, 0, 16'h0040, 8'h00, 1, 0, 16'h1234, 8'h00);
        cyc(1, 1, 0, 16'h0040, 8'h00, 1, 0, 16'h1234, 8'h00);
        chk("pulse_addr", mem_addr0, 16'h1234);
        chk("pulse_gnt", dma_gnt0, 1'b1);
        cyc(1, 1, 0, 16'h0040, 8'h00, 0, 0, 16'h1234, 8'h00);
        cyc(1, 1, 0, 16'h0040, 8'h00, 0, 0, 16'h1234, 8'h00);
        chk("pulse_return", owner0, 1'b0);
        chk("pulse_gnt_count", gcnt, 1);
        // random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 60) != 0, ($urandom % 4) != 0, $urandom % 2, 16'($urandom),
                8'($urandom), ($urandom % 3) != 0, $urandom % 2, 16'($urandom), 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
